// File: rtl/bin2bcd_seq_16_if.sv
// Handshake and result bundle for the sequential 16-bit binary-to-BCD converter.
// start/bin: a request is taken when start=1 on an edge while busy=0; no ready
// signal exists, a request raised while busy=1 is simply dropped.
interface bin2bcd_seq_16_if;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [3:0]  BCD0;
  logic [3:0]  BCD1;
  logic [3:0]  BCD2;
  logic [3:0]  BCD3;
  logic [3:0]  BCD4;
  logic [1:0]  fsm_state;

  modport master (
    output start, bin,
    input  busy, done, BCD0, BCD1, BCD2, BCD3, BCD4, fsm_state
  );

  modport slave (
    input  start, bin,
    output busy, done, BCD0, BCD1, BCD2, BCD3, BCD4, fsm_state
  );
endinterface

// File: rtl/bin2bcd_seq_16.sv
// Sequential double-dabble converter: 16 adjust-and-shift steps turn a 16-bit
// binary value into five BCD digits, published together with a one-cycle done.
module bin2bcd_seq_16 (
  input  logic               clock,
  input  logic               reset,
  bin2bcd_seq_16_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [35:0] sr_q, sr_d;
  logic [35:0] adj;
  logic [4:0]  cnt_q, cnt_d;
  logic        load_out;

  // Digit fields live in bits 35:16; bits 15:0 hold the binary still to shift in.
  always_comb begin
    adj = sr_q;
    for (int i = 0; i < 5; i++) begin
      if (sr_q[16 + 4*i +: 4] >= 4'd5) begin
        adj[16 + 4*i +: 4] = sr_q[16 + 4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    load_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sr_d    = {20'd0, bus.bin};
          cnt_d   = 5'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = adj << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          state_d = DONE;
        end
      end
      DONE: begin
        load_out = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      sr_q     <= 36'd0;
      cnt_q    <= 5'd0;
      bus.done <= 1'b0;
      bus.BCD0 <= 4'd0;
      bus.BCD1 <= 4'd0;
      bus.BCD2 <= 4'd0;
      bus.BCD3 <= 4'd0;
      bus.BCD4 <= 4'd0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      bus.done <= load_out;
      // Outputs only change here so intermediate shift values never leak out.
      if (load_out) begin
        bus.BCD0 <= sr_q[19:16];
        bus.BCD1 <= sr_q[23:20];
        bus.BCD2 <= sr_q[27:24];
        bus.BCD3 <= sr_q[31:28];
        bus.BCD4 <= sr_q[35:32];
      end
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_bin2bcd_seq_16.sv
// Self-checking bench for bin2bcd_seq_16: directed scenarios plus randomized
// traffic, compared every cycle against a decimal-arithmetic reference model.
module tb_bin2bcd_seq_16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bin2bcd_seq_16_if bus ();

  bin2bcd_seq_16 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    r[19:16] = 4'((v / 10000) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [19:0] dut_bcd();
    return {bus.BCD4, bus.BCD3, bus.BCD2, bus.BCD1, bus.BCD0};
  endfunction

  // Reference model: a conversion takes 17 clocks after acceptance, then the
  // decimal digits of the captured value appear with a one-cycle done.
  int          m_remain;
  logic [15:0] m_val;
  logic [19:0] m_bcd;
  logic        m_done;

  always @(posedge clock) begin
    if (reset) begin
      m_remain <= 0;
      m_bcd    <= 20'd0;
      m_done   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_remain == 0) begin
        if (bus.start) begin
          m_val    <= bus.bin;
          m_remain <= 17;
        end
      end else begin
        m_remain <= m_remain - 1;
        if (m_remain == 1) begin
          m_bcd  <= to_bcd(int'(m_val));
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      check("busy", 32'(bus.busy), 32'(m_remain != 0));
      check("done", 32'(bus.done), 32'(m_done));
      check("bcd", 32'(dut_bcd()), 32'(m_bcd));
      if (bus.done) begin
        for (int i = 0; i < 5; i++) begin
          check("digit_le_9", 32'(dut_bcd() >> (4*i) & 20'hF) <= 32'd9, 32'd1);
        end
        check("bcd4_le_6", 32'(bus.BCD4 <= 4'd6), 32'd1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_done(input int bound, output int n, output int busy_n);
    n = 0;
    busy_n = 0;
    do begin
      tick(1);
      n++;
      if (bus.busy) busy_n++;
    end while (!bus.done && n < bound);
    check("done_seen", 32'(bus.done), 32'd1);
  endtask

  task automatic convert(input logic [15:0] v, output int lat, output int busy_n);
    bus.bin   = v;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    lat = 1;
    busy_n = bus.busy ? 1 : 0;
    while (!bus.done && lat < 40) begin
      tick(1);
      lat++;
      if (bus.busy) busy_n++;
    end
    check("done_seen", 32'(bus.done), 32'd1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  int lat, busy_n, n, dones, gap;
  logic [15:0] edge_vals[17] = '{16'd0, 16'd1, 16'd9, 16'd10, 16'd99, 16'd100,
                                16'd999, 16'd1000, 16'd9999, 16'd10000, 16'd19999,
                                16'd59999, 16'd60000, 16'd65534, 16'd65535,
                                16'h5555, 16'hAAAA};

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.bin   = 16'd0;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_bcd", 32'(dut_bcd()), 32'd0);
    check_en = 1'b1;

    check("model_65535", 32'(to_bcd(65535)), 32'h65535);
    check("model_1234", 32'(to_bcd(1234)), 32'h01234);
    check("model_59999", 32'(to_bcd(59999)), 32'h59999);

    // Zero input: 18 negedges from driving start to seeing done.
    convert(16'd0, lat, busy_n);
    check("zero_latency", 32'(lat), 32'd18);
    check("zero_bcd", 32'(dut_bcd()), 32'h00000);

    convert(16'hFFFF, lat, busy_n);
    check("max_bcd", 32'(dut_bcd()), 32'h65535);
    check("max_busy_cycles", 32'(busy_n), 32'd17);

    // Second start during the conversion must be dropped.
    bus.bin = 16'd1234;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(4);
    bus.bin = 16'd9999;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    bus.bin = 16'd7777;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done) begin
        dones++;
        check("ignore_bcd", 32'(dut_bcd()), 32'h01234);
      end
      tick(1);
    end
    check("ignore_done_count", 32'(dones), 32'd1);

    // start held high across three conversions.
    bus.bin = 16'd9;
    bus.start = 1'b1;
    wait_done(60, n, busy_n);
    check("held1_gap", 32'(n), 32'd18);
    check("held1_bcd", 32'(dut_bcd()), 32'h00009);
    bus.bin = 16'd10;
    wait_done(60, n, busy_n);
    check("held2_gap", 32'(n), 32'd18);
    check("held2_bcd", 32'(dut_bcd()), 32'h00010);
    bus.bin = 16'd59999;
    wait_done(60, n, busy_n);
    check("held3_gap", 32'(n), 32'd18);
    check("held3_bcd", 32'(dut_bcd()), 32'h59999);
    bus.start = 1'b0;

    // Reset in mid-conversion aborts without a done pulse.
    bus.bin = 16'd4321;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(7);
    reset = 1'b1;
    tick(1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_bcd", 32'(dut_bcd()), 32'd0);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    convert(16'd4321, lat, busy_n);
    check("after_abort_latency", 32'(lat), 32'd18);
    check("after_abort_bcd", 32'(dut_bcd()), 32'h04321);

    // Randomized traffic: boundary values first, then random values, with
    // noise on start/bin while busy, varied gaps and occasional resets.
    for (int i = 0; i < 400; i++) begin
      bus.bin   = (i < 17) ? edge_vals[i] : 16'($urandom);
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      n = 0;
      while (!bus.done && n < 40) begin
        bus.bin   = 16'($urandom);
        bus.start = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 199) == 0) reset = 1'b1;
        tick(1);
        reset = 1'b0;
        n++;
      end
      bus.start = 1'b0;
      gap = $urandom_range(0, 2);
      tick(gap);
    end
    tick(25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq_16.md
BIN2BCD_SEQ_16 -- requirements
Module: bin2bcd_seq_16

Interface
REQ-001 Parameters: none; data width fixed at 16 bits in, 5 BCD digits out.
REQ-002 clock  input  1  rising-edge clock for all state; CLOCK_50 at top level.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clock edge.
REQ-004 start  input  1  request conversion of bin; sampled only in IDLE.
REQ-005 bin  input  16  unsigned binary value; captured on the edge that accepts start.
REQ-006 busy  output  1  high while a conversion is in progress (state != IDLE).
REQ-007 done  output  1  one-cycle pulse marking that new BCD outputs are valid.
REQ-008 BCD0  output  4  units digit, registered.
REQ-009 BCD1  output  4  tens digit, registered.
REQ-010 BCD2  output  4  hundreds digit, registered.
REQ-011 BCD3  output  4  thousands digit, registered.
REQ-012 BCD4  output  4  ten-thousands digit (0-6), registered.

Function
REQ-013 Block SHALL be a sequential shift-add-3 (double-dabble) converter and a drop-in upstream feed for the hex_to_7seg digit decoders.
REQ-014 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-015 IDLE with start=1 at edge k: load 36-bit shift register = {20'b0, bin}, clear 5-bit iteration counter, go to SHIFT.
REQ-016 SHIFT, each edge: add 3 to every BCD nibble >= 5, then shift the whole register left by 1 bit, increment the counter.
REQ-017 The 16th shift, at edge k+16, SHALL move the FSM to DONE; no 17th shift SHALL occur.
REQ-018 DONE at edge k+17: load BCD0..BCD4 from the shift register digit fields, set done=1, return to IDLE.
REQ-019 done SHALL be high for exactly the one cycle after edge k+17; latency from start-accept edge to valid outputs is 17 clocks, 18 cycles per conversion.
REQ-020 BCD outputs SHALL hold their last converted value until the next DONE; they SHALL NOT show intermediate shift values.
REQ-021 busy SHALL be high during SHIFT and DONE and low in IDLE.
REQ-022 start while busy=1 SHALL be ignored, with no queuing and no effect on the conversion in flight.
REQ-023 start high in the same cycle done is high SHALL be accepted, since the FSM is in IDLE, giving back-to-back conversions with an 18-cycle period.
REQ-024 start held continuously high SHALL restart a conversion each time IDLE is reached.
REQ-025 Every nibble SHALL stay <= 9 after each adjust-shift; BCD4 SHALL be <= 6 for all inputs.
REQ-026 bin changing after the accept edge SHALL NOT affect the result.

Reset
REQ-027 reset=1 at a clock edge SHALL force IDLE, clear the shift register and counter, and set BCD0..BCD4=0, done=0, busy=0.
REQ-028 reset SHALL take priority over start and abort any conversion in flight, producing no done pulse.
REQ-029 After reset is released, the first start SHALL behave exactly as in REQ-015 to REQ-019.

Verification
REQ-030 reset, then start with bin=0 -> done at edge k+17, BCD4..BCD0 = 0,0,0,0,0.
REQ-031 bin=16'hFFFF (65535) -> BCD4..BCD0 = 6,5,5,3,5; busy high for exactly 17 cycles.
REQ-032 bin=1234, then start pulsed again at k+5 with bin=9999 -> second start ignored, result 0,1,2,3,4, single done pulse.
REQ-033 start held high for 3 conversions with bin=9, 10, 59999 sampled on the accept edges -> done pulses 18 cycles apart with 0,0,0,0,9 / 0,0,0,1,0 / 5,9,9,9,9.
REQ-034 reset asserted at k+8 during conversion of 4321 -> outputs 0, no done pulse, busy low next cycle; a following start with 4321 -> 0,4,3,2,1.
REQ-035 Exhaustive sweep of bin 0..65535 against a reference model -> every result matches and no nibble exceeds 9.
